image_sender: RTL and testbench
===============================

# image_sender

Transmits a 784-byte image held in an on-chip buffer over UART using the image framing protocol (0xBB 0x66, 784 bytes, 0x66 0xBB). It sits on the readback path. It reads the image RAM through a synchronous read port, serialises the frame 8N1 on `tx` and raises `done` when the last stop bit has finished. Its output drives the same framing the host-to-FPGA image path consumes, so a `tx`→`rx` loopback into the image receive path must yield a loaded image.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate. BIT_CYCLES = CLK_FREQ / BAUD_RATE, integer division (868 at defaults).
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to send a frame. Honoured only in IDLE.
- `rd_addr`  out  10  image RAM read address, 0..783.
- `rd_en`  out  1  read strobe. `rd_data` is valid on the cycle after `rd_en`.
- `rd_data`  in  8  image RAM read data.
- `tx`  out  1  UART serial out. Idle high.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse at frame completion.

## Operation
- States: IDLE, HDR1 (0xBB), HDR2 (0x66), DATA, END1 (0x66), END2 (0xBB), DONE. With the macro defined, a CSUM state sits between DATA and END1.
- Transitions:
  - IDLE→HDR1 on `start`.
  - Each byte state advances when its stop bit completes.
  - DATA repeats 784 times, byte index 0..783.
  - END2→DONE, then DONE→IDLE after one cycle.
- Byte serialiser:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit is held exactly BIT_CYCLES cycles.
  - Bit counter 0..9; baud counter 0..BIT_CYCLES-1.
- Prefetch:
  - The read for data byte k is issued while the previous byte is on the line. Byte 0 is read during HDR2.
  - Its data is latched into a one-byte holding register.
  - Bytes go out back to back with no idle cycles between stop bit and next start bit, anywhere in the frame.
- Reads:
  - `rd_en` is a one-cycle pulse.
  - Addresses are issued ascending 0..783, each exactly once per frame.
  - `rd_addr` holds its last value when `rd_en` is low.
- The byte counter is 10 bits. There is no wrap: DATA exits when index 783 has been sent.
- `start` while `busy` is ignored, not queued.
- `start` asserted on the DONE cycle is ignored. It is accepted from the following cycle (IDLE).

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0. State is IDLE and all counters are 0.
- `start` sampled high at cycle 0 → `tx` falls (start bit of 0xBB) at cycle 1, and `busy` rises at cycle 1.
- Frame length is N×10×BIT_CYCLES cycles, with N=788 (789 with the macro).
- `tx` carries the stop bit of the last byte through cycle N×10×BIT_CYCLES.
- At cycle N×10×BIT_CYCLES+1:
  - `done`=1 for one cycle.
  - `busy`=0.
  - `tx`=1.
- Reset mid-frame: on the next edge, all outputs return to their reset values and `tx` goes high immediately. No partial byte completes and `done` does not pulse.
- RAM read latency is exactly 1 cycle. The design must not rely on `rd_data` beyond the cycle after `rd_en`.

## Configuration
- `IMG_SENDER_CHECKSUM_EN`:
  - Defined: after byte 783, one extra byte is sent, equal to the XOR of all 784 data bytes, then 0x66 0xBB. The frame is 789 bytes. The XOR accumulator clears on entry to HDR1.
  - Undefined: no checksum logic is built. The frame is exactly 788 bytes.

## Test plan
- Reset: hold `rst` 3 cycles, then check `tx`=1, `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, and `tx` stays high for 1000 cycles with no `start`.
- Full frame, CLK_FREQ=1_000_000, BAUD_RATE=100_000 (10 cycles/bit), RAM[i]=i mod 256:
  - UART monitor decodes BB 66 00 01 … 0F 66 BB.
  - `done` pulses at cycle 78801 after `start`.
  - No idle gap between bytes.
- Read port: count `rd_en` pulses per frame = 784, with addresses strictly 0..783 ascending.
- `start` pulsed at cycles 5000 and 40000 mid-frame → exactly one frame sent, one `done` pulse.
- `rst` at cycle 30000 mid-frame → `tx`=1 and `busy`=0 on the next cycle, no `done`. A following `start` sends a complete correct frame.
- With `IMG_SENDER_CHECKSUM_EN`, RAM[i]=i mod 256 → byte 787 = 0x00 (XOR of 0..255 three times plus 0..15 = 0x00). With RAM all 0x5A → checksum 0x00. With RAM[0]=0x01 and the rest 0x00 → checksum 0x01, and `done` at cycle 78901.

Source files
------------

// File: rtl/image_sender_if.sv
// Handshake and RAM-read bundle for image_sender.
// The master side is the sender; the slave side is the RAM and host logic.
interface image_sender_if;
  logic       start;
  logic [9:0] rd_addr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    input  start,
    input  rd_data,
    output rd_addr,
    output rd_en,
    output tx,
    output busy,
    output done
  );

  modport slave (
    output start,
    output rd_data,
    input  rd_addr,
    input  rd_en,
    input  tx,
    input  busy,
    input  done
  );
endinterface

// File: rtl/image_sender.sv
// Streams a 784-byte image as a UART frame: BB 66 <784 data bytes> 66 BB, 8N1.
// Define IMG_SENDER_CHECKSUM_EN to append an XOR checksum byte after the data.
module image_sender #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic          clk,
  input  logic          rst,
  image_sender_if.master bus
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
  localparam logic [9:0] LAST_IDX = 10'd783;
  localparam logic [7:0] SYNC_A   = 8'hBB;
  localparam logic [7:0] SYNC_B   = 8'h66;

`ifdef IMG_SENDER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR1, S_HDR2, S_DATA, S_CSUM, S_END1, S_END2, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR1, S_HDR2, S_DATA, S_END1, S_END2, S_DONE
  } state_t;
`endif

  state_t            state_reg, state_next;
  logic [BAUD_W-1:0] baud_cnt_reg, baud_cnt_next;
  logic [3:0]        bit_cnt_reg, bit_cnt_next;
  logic [9:0]        byte_idx_reg, byte_idx_next;
  logic [7:0]        cur_byte_reg, cur_byte_next;
  logic [7:0]        hold_reg, hold_next;
  logic              rd_pending_reg, rd_pending_next;
  logic              rd_en_reg, rd_en_next;
  logic [9:0]        rd_addr_reg, rd_addr_next;
  logic              tx_reg, tx_next;
  logic              byte_end;
  logic              load_data;
  logic [7:0]        load_byte;
`ifdef IMG_SENDER_CHECKSUM_EN
  logic [7:0]        csum_reg, csum_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      baud_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      byte_idx_reg   <= '0;
      cur_byte_reg   <= '0;
      hold_reg       <= '0;
      rd_pending_reg <= 1'b0;
      rd_en_reg      <= 1'b0;
      rd_addr_reg    <= '0;
      tx_reg         <= 1'b1;
`ifdef IMG_SENDER_CHECKSUM_EN
      csum_reg       <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      baud_cnt_reg   <= baud_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      byte_idx_reg   <= byte_idx_next;
      cur_byte_reg   <= cur_byte_next;
      hold_reg       <= hold_next;
      rd_pending_reg <= rd_pending_next;
      rd_en_reg      <= rd_en_next;
      rd_addr_reg    <= rd_addr_next;
      tx_reg         <= tx_next;
`ifdef IMG_SENDER_CHECKSUM_EN
      csum_reg       <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    baud_cnt_next   = baud_cnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    byte_idx_next   = byte_idx_reg;
    cur_byte_next   = cur_byte_reg;
    // RAM data is only valid the cycle after the strobe, so capture it right then.
    hold_next       = rd_pending_reg ? bus.rd_data : hold_reg;
    rd_pending_next = rd_en_reg;
    rd_en_next      = 1'b0;
    rd_addr_next    = rd_addr_reg;
    tx_next         = tx_reg;
    byte_end        = 1'b0;
    load_data       = 1'b0;
    load_byte       = cur_byte_reg;
`ifdef IMG_SENDER_CHECKSUM_EN
    csum_next       = csum_reg;
`endif

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next    = S_HDR1;
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
          cur_byte_next = SYNC_A;
          tx_next       = 1'b0;
`ifdef IMG_SENDER_CHECKSUM_EN
          csum_next     = '0;
`endif
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
      end
      default: begin
        if (baud_cnt_reg == BAUD_LAST) begin
          baud_cnt_next = '0;
          if (bit_cnt_reg == 4'd9) begin
            byte_end = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
            tx_next      = (bit_cnt_reg == 4'd8) ? 1'b1 : cur_byte_reg[bit_cnt_reg[2:0]];
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
    endcase

    // Fetch the next data byte at the first cycle of the byte currently on the line.
    if (baud_cnt_reg == '0 && bit_cnt_reg == 4'd0 &&
        (state_reg == S_HDR2 || (state_reg == S_DATA && byte_idx_reg != LAST_IDX))) begin
      rd_en_next   = 1'b1;
      rd_addr_next = (state_reg == S_HDR2) ? 10'd0 : byte_idx_reg + 10'd1;
    end

    if (byte_end) begin
      bit_cnt_next = '0;
      tx_next      = 1'b0;
      case (state_reg)
        S_HDR1: begin
          state_next = S_HDR2;
          load_byte  = SYNC_B;
        end
        S_HDR2: begin
          state_next    = S_DATA;
          byte_idx_next = '0;
          load_byte     = hold_reg;
          load_data     = 1'b1;
        end
        S_DATA: begin
          if (byte_idx_reg == LAST_IDX) begin
`ifdef IMG_SENDER_CHECKSUM_EN
            state_next = S_CSUM;
            load_byte  = csum_reg;
`else
            state_next = S_END1;
            load_byte  = SYNC_B;
`endif
          end else begin
            byte_idx_next = byte_idx_reg + 10'd1;
            load_byte     = hold_reg;
            load_data     = 1'b1;
          end
        end
`ifdef IMG_SENDER_CHECKSUM_EN
        S_CSUM: begin
          state_next = S_END1;
          load_byte  = SYNC_B;
        end
`endif
        S_END1: begin
          state_next = S_END2;
          load_byte  = SYNC_A;
        end
        S_END2: begin
          state_next = S_DONE;
          tx_next    = 1'b1;
        end
        default: begin
          state_next = S_IDLE;
          tx_next    = 1'b1;
        end
      endcase
      cur_byte_next = load_byte;
    end

`ifdef IMG_SENDER_CHECKSUM_EN
    // Accumulate as each data byte is committed to the line; byte 783 is in before DATA exits.
    if (load_data) begin
      csum_next = csum_reg ^ hold_reg;
    end
`endif
  end

  assign bus.tx      = tx_reg;
  assign bus.rd_en   = rd_en_reg;
  assign bus.rd_addr = rd_addr_reg;
  assign bus.busy    = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign bus.done    = (state_reg == S_DONE);

endmodule

// File: tb/tb_image_sender.sv
// Directed bench for image_sender: UART decode, read-port log, done timing, reset and start corner cases.
module tb_image_sender;

  localparam int CLK_FREQ   = 1_000_000;
  localparam int BAUD_RATE  = 500_000;
  localparam int BC         = 2;
  localparam int BYTE_CYC   = 10 * BC;
`ifdef IMG_SENDER_CHECKSUM_EN
  localparam int N_BYTES    = 789;
  localparam int DONE_AT    = 15781;
`else
  localparam int N_BYTES    = 788;
  localparam int DONE_AT    = 15761;
`endif
  localparam int TIMEOUT    = 20000;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  image_sender_if bus ();

  image_sender #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:783];
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  // UART decoder and read/done logs, sampled on the falling edge.
  logic [7:0] mon_q [$];
  logic [7:0] mon_byte;
  bit   mon_active = 0;
  bit   in_frame = 0;
  int   mon_cnt = 0;
  int   bit_i = 0;
  int   prev_start = 0;
  int   gap_bad = 0;
  int   framing_bad = 0;
  int   rd_exp = 0;
  int   rd_cnt = 0;
  int   rd_bad = 0;
  bit   rd_prev = 0;
  int   done_cnt = 0;
  int   last_base = 0;

  always @(negedge clk) begin
    if (rst || bus.busy !== 1'b1) begin
      in_frame   = 0;
      mon_active = 0;
    end else if (!mon_active) begin
      if (bus.tx === 1'b0) begin
        if (in_frame && (cyc - prev_start) != BYTE_CYC) gap_bad++;
        in_frame   = 1;
        prev_start = cyc;
        mon_active = 1;
        mon_cnt    = 0;
        mon_byte   = 8'h00;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % BC == BC / 2) begin
        bit_i = mon_cnt / BC;
        if (bit_i == 0) begin
          if (bus.tx !== 1'b0) framing_bad++;
        end else if (bit_i <= 8) begin
          mon_byte[bit_i-1] = bus.tx;
        end else begin
          if (bus.tx !== 1'b1) framing_bad++;
          mon_q.push_back(mon_byte);
          mon_active = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst || bus.busy !== 1'b1) rd_exp = 0;
    if (bus.rd_en === 1'b1) begin
      if (bus.rd_addr !== 10'(rd_exp) || rd_prev) rd_bad++;
      rd_exp++;
      rd_cnt++;
    end
    rd_prev = (bus.rd_en === 1'b1);
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int j);
    logic [7:0] x;
    x = 8'h00;
    if (j == 0 || j == N_BYTES - 1) return 8'hBB;
    if (j == 1 || j == N_BYTES - 2) return 8'h66;
`ifdef IMG_SENDER_CHECKSUM_EN
    if (j == 786) begin
      for (int i = 0; i < 784; i++) x ^= mem[i];
      return x;
    end
`endif
    return mem[j-2];
  endfunction

  task automatic run_frame(input string tag, input bit mid_starts);
    int t0, qb, db, rb, rbad, gb, fb, el;
    qb = mon_q.size(); db = done_cnt; rb = rd_cnt; rbad = rd_bad; gb = gap_bad; fb = framing_bad;
    last_base = qb;
    @(negedge clk);
    bus.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "/tx_start_bit"}, 32'(bus.tx), 32'd0);
    check({tag, "/busy_rise"}, 32'(bus.busy), 32'd1);
    while (bus.done !== 1'b1 && (cyc - t0) < TIMEOUT) begin
      @(negedge clk);
      bus.start = mid_starts && ((cyc - t0) == 5000 || (cyc - t0) == 12000);
    end
    el = cyc - t0;
    check({tag, "/done_cycle"}, 32'(el), 32'(DONE_AT));
    check({tag, "/busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, "/tx_at_done"}, 32'(bus.tx), 32'd1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "/done_width"}, 32'(bus.done), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "/start_in_done_ignored"}, 32'(bus.busy), 32'd0);
    check({tag, "/done_pulses"}, 32'(done_cnt - db), 32'd1);
    check({tag, "/byte_count"}, 32'(mon_q.size() - qb), 32'(N_BYTES));
    for (int j = 0; j < N_BYTES; j++) begin
      if (qb + j < mon_q.size())
        check($sformatf("%s/byte%0d", tag, j), 32'(mon_q[qb+j]), 32'(exp_byte(j)));
    end
    check({tag, "/rd_pulses"}, 32'(rd_cnt - rb), 32'd784);
    check({tag, "/rd_order"}, 32'(rd_bad - rbad), 32'd0);
    check({tag, "/byte_gaps"}, 32'(gap_bad - gb), 32'd0);
    check({tag, "/framing"}, 32'(framing_bad - fb), 32'd0);
    $display("frame %s: %0d bytes, done at +%0d", tag, mon_q.size() - qb, el);
  endtask

  initial begin
    int low, db, t0;
    rst = 1'b1;
    bus.start = 1'b0;
    for (int i = 0; i < 784; i++) mem[i] = 8'(i % 256);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst/tx", 32'(bus.tx), 32'd1);
    check("rst/busy", 32'(bus.busy), 32'd0);
    check("rst/done", 32'(bus.done), 32'd0);
    check("rst/rd_en", 32'(bus.rd_en), 32'd0);
    check("rst/rd_addr", 32'(bus.rd_addr), 32'd0);
    low = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) low++;
    end
    check("idle/tx_low_cycles", 32'(low), 32'd0);

    // Ramp image: i mod 256.
    run_frame("ramp", 1'b0);
    check("ramp/first_data", 32'(mon_q[last_base+2]), 32'h00);
    check("ramp/byte15", 32'(mon_q[last_base+17]), 32'h0F);
    check("ramp/byte256", 32'(mon_q[last_base+258]), 32'h00);
    check("ramp/byte783", 32'(mon_q[last_base+785]), 32'h0F);
`ifdef IMG_SENDER_CHECKSUM_EN
    check("ramp/csum", 32'(mon_q[last_base+786]), 32'h00);
`endif

    // Constant 0x5A image with extra starts issued mid-frame.
    for (int i = 0; i < 784; i++) mem[i] = 8'h5A;
    run_frame("mid_start", 1'b1);
    check("mid_start/byte500", 32'(mon_q[last_base+502]), 32'h5A);
`ifdef IMG_SENDER_CHECKSUM_EN
    check("mid_start/csum", 32'(mon_q[last_base+786]), 32'h00);
`endif

    // Reset in the middle of a frame.
    db = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    while ((cyc - t0) < 8000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst/tx", 32'(bus.tx), 32'd1);
    check("midrst/busy", 32'(bus.busy), 32'd0);
    check("midrst/rd_en", 32'(bus.rd_en), 32'd0);
    check("midrst/rd_addr", 32'(bus.rd_addr), 32'd0);
    repeat (1000) @(negedge clk);
    check("midrst/no_done", 32'(done_cnt - db), 32'd0);
    check("midrst/tx_idle", 32'(bus.tx), 32'd1);

    // Single 0x01 at address 0, zeros elsewhere.
    for (int i = 0; i < 784; i++) mem[i] = 8'h00;
    mem[0] = 8'h01;
    run_frame("after_rst", 1'b0);
    check("after_rst/byte0", 32'(mon_q[last_base+2]), 32'h01);
    check("after_rst/byte1", 32'(mon_q[last_base+3]), 32'h00);
`ifdef IMG_SENDER_CHECKSUM_EN
    check("after_rst/csum", 32'(mon_q[last_base+786]), 32'h01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
